uart_tx_word_packer: RTL and testbench

Parametrised successor to the fixed 32-bit float-to-byte UART transmit buffer. Accepts words of WORD_BYTES bytes through a valid/ready port into a DEPTH-word FIFO. Serialises each word into bytes for the byte-wide UART transmitter using the tx_start/tx_busy handshake. Byte order is selectable, and optional framing adds a sync byte before each word and an XOR checksum byte after it.

---
 rtl/uart_tx_word_packer_if.sv | 35 +++
 rtl/uart_tx_word_packer.sv | 202 ++++++++++++++++++++
 tb/tb_uart_tx_word_packer.sv | 355 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_word_packer_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : uart_tx_word_packer_if
// Brief    : Word input, UART byte handshake and status bundle for the
//            UART transmit word packer.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_tx_word_packer_if #(
  parameter int WORD_BYTES = 4,
  parameter int DEPTH      = 4
) ();
  logic [8*WORD_BYTES-1:0] in_data;
  logic                    in_valid;
  logic                    in_ready;
  logic                    tx_busy;
  logic [7:0]              tx_data;
  logic                    tx_start;
  logic                    busy;
  logic [$clog2(DEPTH):0]  level;
  logic                    overflow;

  // Packer side
  modport slave (
    input  in_data, in_valid, tx_busy,
    output in_ready, tx_data, tx_start, busy, level, overflow
  );

  // Word producer / UART side
  modport master (
    output in_data, in_valid, tx_busy,
    input  in_ready, tx_data, tx_start, busy, level, overflow
  );
endinterface
`default_nettype wire

// File: rtl/uart_tx_word_packer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : uart_tx_word_packer
// Brief    : Buffers WORD_BYTES-wide words in a DEPTH-word FIFO and feeds them
//            byte by byte to a UART transmitter over tx_start/tx_busy, with
//            selectable byte order and optional sync/XOR-checksum framing.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_word_packer #(
  parameter int         WORD_BYTES = 4,
  parameter int         DEPTH      = 4,
  parameter int         MSB_FIRST  = 1,
  parameter int         FRAME_EN   = 0,
  parameter logic [7:0] SYNC_BYTE  = 8'hA5
) (
  input wire clk,
  input wire reset,
  uart_tx_word_packer_if.slave bus
);

  localparam int c_w       = 8 * WORD_BYTES;
  localparam int c_ptr_w   = $clog2(DEPTH);
  localparam int c_lvl_w   = c_ptr_w + 1;
  localparam bit c_frame   = (FRAME_EN != 0);
  localparam int c_nbytes  = WORD_BYTES + (c_frame ? 2 : 0);
  localparam int c_idx_w   = $clog2(c_nbytes + 1);

  localparam logic [c_idx_w-1:0] c_last = c_idx_w'(c_nbytes - 1);
  localparam logic [c_lvl_w-1:0] c_full = c_lvl_w'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_SEND    = 3'd2,
    S_WAIT_HI = 3'd3,
    S_WAIT_LO = 3'd4
  } state_t;

  // FIFO storage and bookkeeping
  logic [c_w-1:0]     r_mem [DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_lvl_w-1:0] r_count;
  logic               r_overflow;
  logic               w_full;
  logic               w_push;
  logic               w_pop;

  // Serialiser
  state_t             r_state;
  state_t             w_state_next;
  logic               w_tx_start;
  logic               w_load;
  logic               w_advance;
  logic [c_w-1:0]     w_head;
  logic [c_w-1:0]     w_head_ordered;
  logic [c_w-1:0]     r_shift;
  logic [c_idx_w-1:0] r_idx;
  logic [7:0]         r_csum;
  logic [7:0]         r_tx_data;
  logic               w_cur_is_data;
  logic               w_next_is_csum;

  // Full is judged on the registered count only, so a pop in the same cycle
  // never makes room for a push.
  assign w_full = (r_count == c_full);
  assign w_push = bus.in_valid && !w_full;
  assign w_pop  = w_load;
  assign w_head = r_mem[r_rd_ptr];

  // Word storage; contents need no reset because the pointers define validity
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= bus.in_data;
    end
  end

  // FIFO pointers, occupancy and the dropped-word pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_lvl_w'(1);
        2'b01:   r_count <= r_count - c_lvl_w'(1);
        default: r_count <= r_count;
      endcase
      r_overflow <= bus.in_valid && w_full;
    end
  end

  // Reorder the head word so the first data byte to send always sits in the
  // low byte; the serialiser then just shifts right by one byte per data byte.
  if (MSB_FIRST != 0) begin : g_msb_first
    for (genvar g = 0; g < WORD_BYTES; g++) begin : g_byte
      assign w_head_ordered[8*g +: 8] = w_head[8*(WORD_BYTES-1-g) +: 8];
    end
  end else begin : g_lsb_first
    assign w_head_ordered = w_head;
  end

  // Position 0 is the sync byte and the last position the checksum when
  // framing is on; every other position carries payload.
  assign w_cur_is_data  = !c_frame || ((r_idx != '0) && (r_idx != c_last));
  assign w_next_is_csum = c_frame && ((r_idx + c_idx_w'(1)) == c_last);

  // Serialiser state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Serialiser next-state and handshake decode
  always_comb begin
    w_state_next = r_state;
    w_tx_start   = 1'b0;
    w_load       = 1'b0;
    w_advance    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_count != '0) begin
          w_state_next = S_LOAD;
        end
      end
      S_LOAD: begin
        w_load       = 1'b1;
        w_state_next = S_SEND;
      end
      S_SEND: begin
        if (!bus.tx_busy) begin
          w_tx_start   = 1'b1;
          w_state_next = S_WAIT_HI;
        end
      end
      S_WAIT_HI: begin
        if (bus.tx_busy) begin
          w_state_next = S_WAIT_LO;
        end
      end
      S_WAIT_LO: begin
        if (!bus.tx_busy) begin
          if (r_idx == c_last) begin
            w_state_next = S_IDLE;
          end else begin
            w_advance    = 1'b1;
            w_state_next = S_SEND;
          end
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Byte datapath: tx_data is registered one step ahead so it is already
  // stable in the cycle tx_start fires and holds until the next advance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shift   <= '0;
      r_idx     <= '0;
      r_csum    <= '0;
      r_tx_data <= '0;
    end else if (w_load) begin
      r_shift   <= w_head_ordered;
      r_idx     <= '0;
      r_csum    <= '0;
      r_tx_data <= c_frame ? SYNC_BYTE : w_head_ordered[7:0];
    end else begin
      if (w_tx_start && w_cur_is_data) begin
        r_shift <= r_shift >> 8;
        r_csum  <= r_csum ^ r_tx_data;
      end
      if (w_advance) begin
        r_idx     <= r_idx + c_idx_w'(1);
        r_tx_data <= w_next_is_csum ? r_csum : r_shift[7:0];
      end
    end
  end

  assign bus.in_ready = !w_full;
  assign bus.tx_data  = r_tx_data;
  assign bus.tx_start = w_tx_start;
  assign bus.busy     = (r_state != S_IDLE);
  assign bus.level    = r_count;
  assign bus.overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_word_packer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_uart_tx_word_packer
// Brief    : Self-checking bench for uart_tx_word_packer in three
//            configurations, with a UART busy model and byte-stream reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_word_packer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  typedef struct {
    int         id;
    logic [7:0] b;
  } byte_rec_t;

  typedef struct {
    bit          valid;
    logic [31:0] data;
    bit          acc;
    int          lvl;
    bit          rdy;
    bit          ovf;
  } vec_t;

  localparam int c_wb    [3] = '{4, 4, 2};
  localparam int c_depth [3] = '{4, 4, 8};
  localparam bit c_msb   [3] = '{1'b1, 1'b0, 1'b1};
  localparam bit c_frame [3] = '{1'b0, 1'b1, 1'b0};

  byte_rec_t mon_q [$];
  byte_rec_t exp_q [$];
  vec_t      tbl   [9];

  logic [63:0] din        [3];
  logic        vin        [3];
  logic        force_busy [3];
  int          busy_cnt   [3];
  int          busy_len   [3];
  logic        tbusy      [3];
  logic        st         [3];
  logic [7:0]  td         [3];
  logic        bsy        [3];
  int          lv         [3];
  logic        rdy        [3];
  logic        ovf        [3];

  int nvec  = 0;
  int nfail = 0;

  uart_tx_word_packer_if #(.WORD_BYTES(4), .DEPTH(4)) if0 ();
  uart_tx_word_packer_if #(.WORD_BYTES(4), .DEPTH(4)) if1 ();
  uart_tx_word_packer_if #(.WORD_BYTES(2), .DEPTH(8)) if2 ();

  uart_tx_word_packer #(.WORD_BYTES(4), .DEPTH(4), .MSB_FIRST(1), .FRAME_EN(0), .SYNC_BYTE(8'hA5))
    dut0 (.clk(clk), .reset(reset), .bus(if0));
  uart_tx_word_packer #(.WORD_BYTES(4), .DEPTH(4), .MSB_FIRST(0), .FRAME_EN(1), .SYNC_BYTE(8'hA5))
    dut1 (.clk(clk), .reset(reset), .bus(if1));
  uart_tx_word_packer #(.WORD_BYTES(2), .DEPTH(8), .MSB_FIRST(1), .FRAME_EN(0), .SYNC_BYTE(8'hA5))
    dut2 (.clk(clk), .reset(reset), .bus(if2));

  for (genvar k = 0; k < 3; k++) begin : g_busy
    assign tbusy[k] = force_busy[k] | (busy_cnt[k] > 0);
  end

  assign if0.in_data = din[0][31:0];
  assign if0.in_valid = vin[0];
  assign if0.tx_busy = tbusy[0];
  assign if1.in_data = din[1][31:0];
  assign if1.in_valid = vin[1];
  assign if1.tx_busy = tbusy[1];
  assign if2.in_data = din[2][15:0];
  assign if2.in_valid = vin[2];
  assign if2.tx_busy = tbusy[2];

  assign st[0] = if0.tx_start;  assign td[0] = if0.tx_data;  assign bsy[0] = if0.busy;
  assign lv[0] = int'(if0.level); assign rdy[0] = if0.in_ready; assign ovf[0] = if0.overflow;
  assign st[1] = if1.tx_start;  assign td[1] = if1.tx_data;  assign bsy[1] = if1.busy;
  assign lv[1] = int'(if1.level); assign rdy[1] = if1.in_ready; assign ovf[1] = if1.overflow;
  assign st[2] = if2.tx_start;  assign td[2] = if2.tx_data;  assign bsy[2] = if2.busy;
  assign lv[2] = int'(if2.level); assign rdy[2] = if2.in_ready; assign ovf[2] = if2.overflow;

  // UART model: busy for busy_len cycles starting the cycle after a request
  always @(posedge clk or posedge reset) begin
    for (int k = 0; k < 3; k++) begin
      if (reset)                busy_cnt[k] <= 0;
      else if (st[k])           busy_cnt[k] <= busy_len[k];
      else if (busy_cnt[k] > 0) busy_cnt[k] <= busy_cnt[k] - 1;
    end
  end

  // Record every byte the UART is asked to send
  always @(posedge clk) begin : p_mon
    byte_rec_t r;
    if (!reset) begin
      for (int k = 0; k < 3; k++) begin
        if (st[k]) begin
          r.id = k;
          r.b  = td[k];
          mon_q.push_back(r);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, actual running required done");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Reference: the bytes one accepted word must produce on the UART
  function automatic void model_word(input int k, input logic [63:0] w);
    int         n;
    logic [7:0] cs;
    byte_rec_t  r;
    n    = c_wb[k];
    cs   = 8'h00;
    r.id = k;
    if (c_frame[k]) begin
      r.b = 8'hA5;
      exp_q.push_back(r);
    end
    for (int i = 0; i < n; i++) begin
      int sh;
      sh  = c_msb[k] ? (n - 1 - i) : i;
      r.b = 8'((w >> (8 * sh)) & 64'hFF);
      cs  = cs ^ r.b;
      exp_q.push_back(r);
    end
    if (c_frame[k]) begin
      r.b = cs;
      exp_q.push_back(r);
    end
  endfunction

  task automatic compare_stream(input string name);
    chk({name, "_count"}, 64'(mon_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++) begin
      chk(name, {8'(mon_q[i].id), mon_q[i].b}, {8'(exp_q[i].id), exp_q[i].b});
    end
    mon_q.delete();
    exp_q.delete();
  endtask

  task automatic wait_idle(input int k, input string name);
    int n;
    n = 0;
    while (n < 4000 && !(bsy[k] == 1'b0 && lv[k] == 0 && busy_cnt[k] == 0)) begin
      tick();
      n++;
    end
    chk({name, "_idle_reached"}, 64'(n < 4000), 64'd1);
  endtask

  task automatic push(input int k, input logic [63:0] w, output bit acc);
    vin[k] = 1'b1;
    din[k] = w;
    acc    = rdy[k];
    tick();
    vin[k] = 1'b0;
    if (acc) model_word(k, w);
  endtask

  task automatic chk_reset_outputs(input int k, input string tag);
    chk($sformatf("%s%0d_tx_data", tag, k), td[k], 8'h00);
    chk($sformatf("%s%0d_tx_start", tag, k), st[k], 1'b0);
    chk($sformatf("%s%0d_busy", tag, k), bsy[k], 1'b0);
    chk($sformatf("%s%0d_level", tag, k), lv[k], 0);
    chk($sformatf("%s%0d_overflow", tag, k), ovf[k], 1'b0);
    chk($sformatf("%s%0d_in_ready", tag, k), rdy[k], 1'b1);
  endtask

  initial begin
    bit   acc;
    bit   prev_rej;
    int   nacc;
    int   n;
    logic [7:0] t2_bytes [6];
    byte_rec_t  r;

    // Back-to-back push/overflow table for the 4-deep, 4-byte packer
    tbl[0] = '{1'b1, 32'h01020304, 1'b1, 1, 1'b1, 1'b0};
    tbl[1] = '{1'b1, 32'h11121314, 1'b1, 2, 1'b1, 1'b0};
    tbl[2] = '{1'b1, 32'h21222324, 1'b1, 2, 1'b1, 1'b0};
    tbl[3] = '{1'b1, 32'h31323334, 1'b1, 3, 1'b1, 1'b0};
    tbl[4] = '{1'b1, 32'h41424344, 1'b1, 4, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 32'h51525354, 1'b0, 4, 1'b0, 1'b1};
    tbl[6] = '{1'b1, 32'h61626364, 1'b0, 4, 1'b0, 1'b1};
    tbl[7] = '{1'b0, 32'h00000000, 1'b0, 4, 1'b0, 1'b0};
    tbl[8] = '{1'b0, 32'h00000000, 1'b0, 4, 1'b0, 1'b0};
    t2_bytes = '{8'hA5, 8'h78, 8'h56, 8'h34, 8'h12, 8'h08};

    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      din[k] = '0; vin[k] = 1'b0; force_busy[k] = 1'b0; busy_len[k] = 4;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) chk_reset_outputs(k, "rst");
    reset = 1'b0;
    tick();

    // T1: single word, first-request latency and byte order
    din[0] = 64'h40400000;
    vin[0] = 1'b1;
    chk("t1_ready", rdy[0], 1'b1);
    tick();
    vin[0] = 1'b0;
    model_word(0, 64'h40400000);
    chk("t1_level_c1", lv[0], 1);
    chk("t1_busy_c1", bsy[0], 1'b0);
    chk("t1_start_c1", st[0], 1'b0);
    tick();
    chk("t1_busy_c2", bsy[0], 1'b1);
    chk("t1_start_c2", st[0], 1'b0);
    tick();
    chk("t1_start_c3", st[0], 1'b1);
    chk("t1_data_c3", td[0], 8'h40);
    chk("t1_level_c3", lv[0], 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t1_data_hold", td[0], 8'h40);
    end
    wait_idle(0, "t1");
    chk("t1_busy_end", bsy[0], 1'b0);
    compare_stream("t1");

    // T2: framed, LSB first, checksum byte
    push(1, 64'h12345678, acc);
    exp_q.delete();
    for (int i = 0; i < 6; i++) begin
      r.id = 1;
      r.b  = t2_bytes[i];
      exp_q.push_back(r);
    end
    wait_idle(1, "t2");
    compare_stream("t2");

    // T3: back-to-back pushes into a stalled serialiser
    force_busy[0] = 1'b1;
    for (int i = 0; i < 9; i++) begin
      vin[0] = tbl[i].valid;
      din[0] = 64'(tbl[i].data);
      tick();
      if (tbl[i].acc) model_word(0, 64'(tbl[i].data));
      chk($sformatf("t3_level_%0d", i), lv[0], tbl[i].lvl);
      chk($sformatf("t3_ready_%0d", i), rdy[0], tbl[i].rdy);
      chk($sformatf("t3_overflow_%0d", i), ovf[0], tbl[i].ovf);
    end
    vin[0] = 1'b0;
    chk("t3_stall_start", st[0], 1'b0);
    force_busy[0] = 1'b0;
    wait_idle(0, "t3");
    compare_stream("t3");

    // T4: UART already busy before the word arrives
    force_busy[0] = 1'b1;
    push(0, 64'hCAFEF00D, acc);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t4_hold_start", st[0], 1'b0);
    end
    chk("t4_busy_waiting", bsy[0], 1'b1);
    force_busy[0] = 1'b0;
    #1;
    chk("t4_pulse", st[0], 1'b1);
    tick();
    chk("t4_one_pulse", 64'(mon_q.size()), 64'd1);
    chk("t4_pulse_ends", st[0], 1'b0);
    wait_idle(0, "t4");
    compare_stream("t4");

    // T5: reset mid-word in WAIT_LO
    busy_len[0] = 6;
    push(0, 64'h89ABCDEF, acc);
    n = 0;
    while (mon_q.size() < 2 && n < 200) begin
      tick();
      n++;
    end
    chk("t5_second_byte_seen", 64'(mon_q.size()), 64'd2);
    tick();
    tick();
    chk("t5_in_wait", bsy[0], 1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk_reset_outputs(0, "t5_rst");
    void'(exp_q.pop_back());
    void'(exp_q.pop_back());
    @(negedge clk);
    reset = 1'b0;
    tick();
    busy_len[0] = 4;
    push(0, 64'h0BADBEEF, acc);
    wait_idle(0, "t5");
    compare_stream("t5");

    // T6: 2-byte words, 8-deep FIFO filled while UART is stuck, then wrap
    force_busy[2] = 1'b1;
    nacc = 0;
    for (int i = 0; i < 12; i++) begin
      push(2, 64'(16'h1000 + 16'(i) * 16'h0111), acc);
      if (acc) nacc++;
    end
    chk("t6_accepted", nacc, 9);
    chk("t6_level_full", lv[2], 8);
    chk("t6_ready_low", rdy[2], 1'b0);
    force_busy[2] = 1'b0;
    wait_idle(2, "t6");
    compare_stream("t6");
    for (int i = 0; i < 3; i++) push(2, 64'(16'hE000 + 16'(i) * 16'h0123), acc);
    wait_idle(2, "t6_wrap");
    compare_stream("t6_wrap");

    // Randomised traffic and UART latency against the byte-stream reference
    for (int k = 0; k < 3; k++) begin
      for (int c = 0; c < 300; c++) begin
        vin[k]      = ($urandom_range(0, 2) == 0);
        din[k]      = {$urandom(), $urandom()};
        busy_len[k] = int'($urandom_range(1, 5));
        chk($sformatf("rnd%0d_ready", k), rdy[k], 1'(lv[k] != c_depth[k]));
        prev_rej = vin[k] && !rdy[k];
        if (vin[k] && rdy[k]) model_word(k, din[k]);
        tick();
        chk($sformatf("rnd%0d_overflow", k), ovf[k], prev_rej);
      end
      vin[k] = 1'b0;
      wait_idle(k, $sformatf("rnd%0d", k));
      compare_stream($sformatf("rnd%0d", k));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
`default_nettype wire
